// File: rtl/multi_pulse_timestamper_if.sv
// AXI-Stream style output channel carrying {line_id, ts} words from the timestamper.
interface multi_pulse_timestamper_if #(
  parameter int DW = 32
) ();
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/multi_pulse_timestamper.sv
// N-channel rising-edge timestamper: per-line capture with deadtime, round-robin merge
// into a first-word fall-through FIFO, plus a wrap-marker word on every counter rollover.

module mpt_channel #(
  parameter int TS_W     = 28,
  parameter int DEADTIME = 4
) (
  input  logic            ts_clk,
  input  logic            resetn,
  input  logic            pulse,
  input  logic            enable,
  input  logic [TS_W-1:0] ts,
  input  logic            grant,
  output logic            pend,
  output logic [TS_W-1:0] pend_ts,
  output logic            ovf
);
  localparam int DTW = $clog2(DEADTIME + 2);

  logic            pulse_q, pulse_d;
  logic [DTW-1:0]  dead_q, dead_d;
  logic            pend_q, pend_d;
  logic [TS_W-1:0] pts_q, pts_d;
  logic            hit;

  always_comb begin
    hit     = pulse & ~pulse_q & enable & (dead_q == '0);
    pulse_d = pulse;
    dead_d  = dead_q;
    pend_d  = pend_q & ~grant;
    pts_d   = pts_q;
    ovf     = 1'b0;
    if (dead_q != '0) dead_d = dead_q - DTW'(1);
    if (hit) begin
      dead_d = DTW'(DEADTIME);
      // A capture in the grant cycle replaces the word being drained, so it is not lost.
      if (pend_q && !grant) ovf = 1'b1;
      else begin
        pend_d = 1'b1;
        pts_d  = ts;
      end
    end
  end

  always_ff @(posedge ts_clk or negedge resetn) begin
    if (!resetn) begin
      pulse_q <= 1'b1;
      dead_q  <= '0;
      pend_q  <= 1'b0;
      pts_q   <= '0;
    end else begin
      pulse_q <= pulse_d;
      dead_q  <= dead_d;
      pend_q  <= pend_d;
      pts_q   <= pts_d;
    end
  end

  assign pend    = pend_q;
  assign pend_ts = pts_q;
endmodule

module multi_pulse_timestamper #(
  parameter  int N_CH       = 8,
  parameter  int ID_W       = 4,
  parameter  int TS_W       = 28,
  parameter  int FIFO_DEPTH = 16,
  parameter  int DEADTIME   = 4,
  localparam int DW         = ID_W + TS_W,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      ts_clk,
  input  logic                      resetn,
  input  logic [N_CH-1:0]           pulse_i,
  input  logic [N_CH-1:0]           ch_enable,
  multi_pulse_timestamper_if.master m_axis,
  output logic [15:0]               drop_cnt,
  output logic [LW-1:0]             fifo_level
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int NDW = $clog2(N_CH + 2);

  logic [TS_W-1:0]            ts_q, ts_d, wrap_cnt_q, wrap_cnt_d, mword_q, mword_d;
  logic                       mpend_q, mpend_d;
  logic [PW-1:0]              ptr_q, ptr_d, gnt_id;
  logic [15:0]                drop_q, drop_d;
  logic [LW-1:0]              level_q, level_d;
  logic [AW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DW-1:0]              mem_q [FIFO_DEPTH];
  logic [N_CH-1:0]            pend, ovf, ch_gnt;
  logic [N_CH-1:0][TS_W-1:0]  pend_ts;
  logic                       gnt_found, full, m_gnt, m_ovf, wr_en, pop, wrap;
  logic [DW-1:0]              wr_data;
  logic [NDW-1:0]             n_drop;
  logic [16:0]                drop_sum;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    mpt_channel #(.TS_W(TS_W), .DEADTIME(DEADTIME)) u_ch (
      .ts_clk  (ts_clk),
      .resetn  (resetn),
      .pulse   (pulse_i[i]),
      .enable  (ch_enable[i]),
      .ts      (ts_q),
      .grant   (ch_gnt[i]),
      .pend    (pend[i]),
      .pend_ts (pend_ts[i]),
      .ovf     (ovf[i])
    );
  end

  // Marker outranks channels; channels are served first-pending at or after ptr_q.
  always_comb begin
    int cand;
    cand      = 0;
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 0; k < N_CH; k++) begin
      cand = (int'(ptr_q) + k) % N_CH;
      if (!gnt_found && pend[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = PW'(cand);
      end
    end
    full    = (level_q == LW'(FIFO_DEPTH));
    m_gnt   = ~full & mpend_q;
    wr_en   = ~full & (mpend_q | gnt_found);
    ch_gnt  = '0;
    ptr_d   = ptr_q;
    wr_data = {{ID_W{1'b1}}, mword_q};
    if (!full && !mpend_q && gnt_found) begin
      ch_gnt[gnt_id] = 1'b1;
      ptr_d          = (gnt_id == PW'(N_CH - 1)) ? '0 : gnt_id + PW'(1);
      wr_data        = {ID_W'(gnt_id), pend_ts[gnt_id]};
    end
  end

  always_comb begin
    ts_d       = ts_q + TS_W'(1);
    wrap       = &ts_q;
    wrap_cnt_d = wrap_cnt_q;
    mpend_d    = mpend_q & ~m_gnt;
    mword_d    = mword_q;
    m_ovf      = 1'b0;
    if (wrap) begin
      wrap_cnt_d = wrap_cnt_q + TS_W'(1);
      if (mpend_q && !m_gnt) m_ovf = 1'b1;
      else begin
        mpend_d = 1'b1;
        mword_d = wrap_cnt_d;
      end
    end
    n_drop = NDW'(m_ovf);
    for (int i = 0; i < N_CH; i++) n_drop = n_drop + NDW'(ovf[i]);
    drop_sum = {1'b0, drop_q} + 17'(n_drop);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_comb begin
    pop      = (level_q != '0) & m_axis.tready;
    level_d  = level_q + LW'(wr_en) - LW'(pop);
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
  end

  always_ff @(posedge ts_clk or negedge resetn) begin
    if (!resetn) begin
      ts_q       <= '0;
      wrap_cnt_q <= '0;
      mword_q    <= '0;
      mpend_q    <= 1'b0;
      ptr_q      <= '0;
      drop_q     <= '0;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      ts_q       <= ts_d;
      wrap_cnt_q <= wrap_cnt_d;
      mword_q    <= mword_d;
      mpend_q    <= mpend_d;
      ptr_q      <= ptr_d;
      drop_q     <= drop_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers and level define which entries are live.
  always_ff @(posedge ts_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign m_axis.tvalid = (level_q != '0);
  assign m_axis.tdata  = m_axis.tvalid ? mem_q[rd_ptr_q] : '0;
  assign drop_cnt      = drop_q;
  assign fifo_level    = level_q;
endmodule

// File: tb/tb_multi_pulse_timestamper.sv
// Bench for multi_pulse_timestamper (TS_W=8 so rollovers are quick): directed vectors,
// hand-written corner sequences and random traffic against a queue-based reference model.
module tb_multi_pulse_timestamper;
  localparam int N = 8, TSW = 8, DEPTH = 16, DT = 4, DW = 12;

  logic        ts_clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  pulse_i = '0, ch_enable = '0;
  logic [15:0] drop_cnt;
  logic [4:0]  fifo_level;

  multi_pulse_timestamper_if #(.DW(DW)) ax ();

  multi_pulse_timestamper #(.N_CH(N), .ID_W(4), .TS_W(TSW), .FIFO_DEPTH(DEPTH), .DEADTIME(DT)) dut (
    .ts_clk     (ts_clk),
    .resetn     (resetn),
    .pulse_i    (pulse_i),
    .ch_enable  (ch_enable),
    .m_axis     (ax),
    .drop_cnt   (drop_cnt),
    .fifo_level (fifo_level)
  );

  always #5 ts_clk = ~ts_clk;

  int errs = 0, checks = 0;
  bit chk_on = 0;
  int tsc;
  logic [11:0] seen[$], expq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Cycle index since reset release; equals the DUT counter value modulo 256.
  always @(posedge ts_clk or negedge resetn)
    if (!resetn) tsc <= 0; else tsc <= tsc + 1;

  always @(posedge ts_clk)
    if (resetn && ax.tvalid && ax.tready) seen.push_back(ax.tdata);

  // Reference model: plain arrays and a queue standing in for the FIFO.
  bit [7:0]    m_pq;
  int          m_dead[N], m_pts[N];
  bit          m_pend[N], m_e[N];
  int          m_ts, m_wc, m_mword, m_drop, m_ptr, m_g;
  bit          m_mp, m_mg;
  logic [11:0] q[$];

  always @(posedge ts_clk or negedge resetn) begin
    if (!resetn) begin
      m_pq = '1; m_ts = 0; m_wc = 0; m_mword = 0; m_drop = 0; m_ptr = 0; m_mp = 0;
      q.delete();
      for (int i = 0; i < N; i++) begin m_dead[i] = 0; m_pend[i] = 0; m_pts[i] = 0; end
    end else begin
      for (int i = 0; i < N; i++)
        m_e[i] = pulse_i[i] && !m_pq[i] && ch_enable[i] && m_dead[i] == 0;
      m_mg = 0; m_g = -1;
      if (q.size() < DEPTH) begin
        if (m_mp) m_mg = 1;
        else for (int k = 0; k < N; k++)
          if (m_g < 0 && m_pend[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
      end
      if (q.size() != 0 && ax.tready) void'(q.pop_front());
      if (m_mg) q.push_back(12'(15 * 256 + m_mword));
      else if (m_g >= 0) begin
        q.push_back(12'(m_g * 256 + m_pts[m_g]));
        m_ptr = (m_g + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (m_e[i]) begin
          m_dead[i] = DT;
          if (m_pend[i] && m_g != i) m_drop++;
          else begin m_pend[i] = 1; m_pts[i] = m_ts; end
        end else begin
          if (m_g == i) m_pend[i] = 0;
          if (m_dead[i] > 0) m_dead[i]--;
        end
      end
      if (m_ts == 255) begin
        m_wc = (m_wc + 1) % 256;
        if (m_mp && !m_mg) m_drop++;
        else begin m_mp = 1; m_mword = m_wc; end
      end else if (m_mg) m_mp = 0;
      m_pq = pulse_i;
      m_ts = (m_ts + 1) % 256;
      if (m_drop > 65535) m_drop = 65535;
    end
  end

  always @(negedge ts_clk) if (chk_on) begin
    chk("mdl_tvalid", ax.tvalid, q.size() != 0);
    chk("mdl_tdata", ax.tdata, (q.size() != 0) ? q[0] : 12'h0);
    chk("mdl_level", fifo_level, q.size());
    chk("mdl_drop", drop_cnt, m_drop);
  end

  task automatic do_reset();
    @(negedge ts_clk);
    #2 resetn = 1'b0;
    #1;
    chk("rst_tvalid", ax.tvalid, 0);
    chk("rst_tdata", ax.tdata, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_drop", drop_cnt, 0);
    repeat (2) @(negedge ts_clk);
    #2 resetn = 1'b1;
  endtask

  task automatic wait_ts(input int v);
    int n = 0;
    while (tsc != v && n < 2000) begin @(negedge ts_clk); n++; end
    if (tsc != v) begin
      checks++; errs++;
      $display("FAIL wait_ts: counter at %0d never reached %0d", tsc, v);
    end
  endtask

  task automatic cmp_seen(input string nm);
    chk({nm, "_count"}, seen.size(), expq.size());
    for (int i = 0; i < expq.size() && i < seen.size(); i++)
      chk($sformatf("%s[%0d]", nm, i), seen[i], expq[i]);
  endtask

  typedef struct {
    logic [7:0]  pulse;
    logic [7:0]  en;
    logic        rdy;
    logic        v;
    logic [11:0] d;
    int          lvl;
  } vec_t;
  vec_t tbl[9];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // T1: single edge at ts=100, deadtime rejection, disabled line ignored
    tbl[0] = '{8'h08, 8'h08, 1'b0, 1'b0, 12'h000, 0};
    tbl[1] = '{8'h08, 8'h08, 1'b0, 1'b1, 12'h364, 1};
    tbl[2] = '{8'h00, 8'h08, 1'b0, 1'b1, 12'h364, 1};
    tbl[3] = '{8'h00, 8'h08, 1'b1, 1'b0, 12'h000, 0};
    tbl[4] = '{8'h08, 8'h08, 1'b0, 1'b0, 12'h000, 0};
    tbl[5] = '{8'h10, 8'h08, 1'b0, 1'b0, 12'h000, 0};
    tbl[6] = '{8'h08, 8'h08, 1'b0, 1'b0, 12'h000, 0};
    tbl[7] = '{8'h08, 8'h08, 1'b1, 1'b1, 12'h36A, 1};
    tbl[8] = '{8'h00, 8'h08, 1'b1, 1'b0, 12'h000, 0};

    ax.tready = 1'b0;
    repeat (2) @(posedge ts_clk);
    chk_on = 1;

    do_reset();
    ch_enable = 8'h08;
    wait_ts(100);
    for (int r = 0; r < 9; r++) begin
      pulse_i = tbl[r].pulse; ch_enable = tbl[r].en; ax.tready = tbl[r].rdy;
      @(posedge ts_clk);
      @(negedge ts_clk);
      chk($sformatf("t1_tvalid[%0d]", r), ax.tvalid, tbl[r].v);
      chk($sformatf("t1_tdata[%0d]", r), ax.tdata, tbl[r].d);
      chk($sformatf("t1_level[%0d]", r), fifo_level, tbl[r].lvl);
    end
    pulse_i = '0;

    // T2: three lines rise together, twice; both bursts come out ch0, ch2, ch5
    do_reset();
    seen.delete();
    ch_enable = 8'hFF; ax.tready = 1'b1;
    wait_ts(50); pulse_i = 8'h25; @(negedge ts_clk); pulse_i = '0;
    wait_ts(70); pulse_i = 8'h25; @(negedge ts_clk); pulse_i = '0;
    repeat (8) @(negedge ts_clk);
    expq = '{12'h032, 12'h232, 12'h532, 12'h046, 12'h246, 12'h546};
    cmp_seen("t2_order");

    // T3: ch1 toggling every 2 cycles; only every other rise survives deadtime
    do_reset();
    seen.delete();
    wait_ts(10);
    for (int k = 0; k < 20; k++) begin
      pulse_i = ((k / 2) % 2 == 0) ? 8'h02 : 8'h00;
      @(negedge ts_clk);
    end
    pulse_i = '0;
    repeat (6) @(negedge ts_clk);
    expq = '{12'h10A, 12'h112, 12'h11A};
    cmp_seen("t3_dead");
    chk("t3_drop", drop_cnt, 0);

    // T4: backpressure; 8+8 fill the FIFO, 4 wait pending, 4 more are lost
    do_reset();
    ax.tready = 1'b0;
    wait_ts(20); pulse_i = 8'hFF; @(negedge ts_clk); pulse_i = '0;
    wait_ts(30); pulse_i = 8'hFF; @(negedge ts_clk); pulse_i = '0;
    wait_ts(40); pulse_i = 8'h0F; @(negedge ts_clk); pulse_i = '0;
    wait_ts(50); pulse_i = 8'h0F; @(negedge ts_clk); pulse_i = '0;
    wait_ts(55);
    chk("t4_level", fifo_level, 16);
    chk("t4_drop", drop_cnt, 4);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t4_stall_tdata[%0d]", k), ax.tdata, 12'h014);
      chk($sformatf("t4_stall_tvalid[%0d]", k), ax.tvalid, 1);
      @(negedge ts_clk);
    end
    seen.delete();
    ax.tready = 1'b1;
    repeat (30) @(negedge ts_clk);
    expq.delete();
    for (int k = 0; k < 8; k++) expq.push_back(12'(k * 256 + 20));
    for (int k = 0; k < 8; k++) expq.push_back(12'(k * 256 + 30));
    for (int k = 0; k < 4; k++) expq.push_back(12'(k * 256 + 40));
    cmp_seen("t4_drain");
    chk("t4_drop_after", drop_cnt, 4);

    // T5: rollover markers; an edge on the wrap cycle follows the marker
    do_reset();
    seen.delete();
    wait_ts(255); pulse_i = 8'h04; @(negedge ts_clk); pulse_i = '0;
    repeat (300) @(negedge ts_clk);
    expq = '{12'hF01, 12'h2FF, 12'hF02};
    cmp_seen("t5_wrap");

    // T6: reset with 5 words queued, lines held high across release
    do_reset();
    ax.tready = 1'b0;
    wait_ts(20); pulse_i = 8'h1F;
    repeat (8) @(negedge ts_clk);
    chk("t6_level_before", fifo_level, 5);
    #2 resetn = 1'b0;
    #1;
    chk("t6_tvalid_in_rst", ax.tvalid, 0);
    chk("t6_drop_in_rst", drop_cnt, 0);
    chk("t6_level_in_rst", fifo_level, 0);
    repeat (2) @(negedge ts_clk);
    #2 resetn = 1'b1;
    seen.delete();
    ax.tready = 1'b1;
    repeat (20) @(negedge ts_clk);
    chk("t6_no_events", seen.size(), 0);
    chk("t6_tvalid_after", ax.tvalid, 0);
    pulse_i = '0;

    // Random traffic, alternating mostly-ready and mostly-stalled windows
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) ch_enable = 8'($urandom) | 8'h81;
      pulse_i   = 8'($urandom & $urandom & $urandom);
      ax.tready = ((c / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      @(negedge ts_clk);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
